workout_session: RTL and testbench
==================================

Name: workout_session

Overview:
Parametrised session controller for the treadmill. It replaces free-running timer/distance blocks with one run/pause/stop state machine that drives a BCD elapsed-time counter and a BCD distance accumulator fed by the speed setpoint. It also generates a 1 Hz tick and a display-page index for the HEX mux in the treadmill top level.

Parameters:
CLK_HZ, 50000000, input clock frequency; one second = CLK_HZ cycles
SPEED_W, 8, width of speed input, units 0.1 km/h
DIST_DIGITS, 3, BCD digits of distance, units 0.01 km (10 m)
NUM_PAGES, 3, number of display pages (2..4)
PAGE_SEC, 4, seconds per page in auto-rotate mode (1..15)

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle synchronous pulse: start/resume/clear
pause  in  1  one-cycle pulse: pause
stop  in  1  one-cycle pulse: end session
speed  in  SPEED_W  current belt speed, binary, 0.1 km/h
auto_page  in  1  1 = rotate pages automatically, 0 = use page_sel
page_sel  in  2  manual page select
min_bcd  out  8  minutes, two BCD digits
sec_bcd  out  8  seconds, two BCD digits
dist_bcd  out  4*DIST_DIGITS  distance, BCD, LSD = 0.01 km
state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
page  out  2  current display page
tick_1hz  out  1  one-cycle pulse per elapsed RUN second

Behaviour:
- Reset (reset=0, async): state=IDLE, min/sec/dist=0, prescaler=0, residue=0, page=0, tick_1hz=0.
- Command priority on the same cycle: stop > pause > start.
- IDLE: counters held at 0. start -> RUN. pause and stop are ignored.
- RUN: prescaler counts 0..CLK_HZ-1. On the cycle it holds CLK_HZ-1, it wraps to 0 and raises tick_1hz; time and distance update on that same edge. pause -> PAUSE. stop -> DONE.
- PAUSE: prescaler, time and distance frozen, not cleared. start -> RUN, resuming the prescaler from its frozen count. stop -> DONE.
- DONE: all values held. start -> IDLE and clears all counters; a second start is required to run.
- First tick after start from IDLE occurs exactly CLK_HZ cycles after the edge that samples start.
- Time: sec_bcd counts 00..59. 59 -> 00 with a minute carry. Minutes count 00..99. On the tick that reaches 99:59 the block enters DONE automatically; no wrap.
- Distance per tick: residue(9 bits) += speed. If the result is >= 360, subtract 360 and increment dist_bcd by one LSD (speed/36 m per second; 360 = 10 m). Since speed < 360, at most one increment per tick.
- dist_bcd saturates at all-9s; residue keeps accumulating mod 360.
- Speed changes take effect at the next tick. Only the value sampled on the tick edge is used.
- Page: auto_page=1 in RUN: page advances every PAGE_SEC ticks, wrapping NUM_PAGES-1 -> 0. The page-second counter freezes outside RUN.
- Page: auto_page=0: page = page_sel, or 0 if page_sel >= NUM_PAGES. The change takes effect one cycle after page_sel changes.
- tick_1hz is never asserted outside RUN.

Optional Feature:
WORKOUT_LAP_EN:
- Defined: adds input lap (1-cycle pulse) and outputs lap_time_bcd (16: min,sec) and lap_dist_bcd (4*DIST_DIGITS).
- lap in RUN or PAUSE captures the current min/sec/dist one cycle later. lap is ignored in IDLE/DONE.
- Lap registers clear on reset and on the DONE->IDLE start.
- If lap coincides with a tick, the lap registers capture the post-tick values.
- Undefined: no lap port and no lap registers; all other behaviour identical.

Test Plan:
- CLK_HZ=10, speed=120, start, run 65 ticks -> min=01 sec=05; residue reaches 360 every 3 ticks -> dist_bcd=021 (0.21 km), tick_1hz 65 pulses.
- Start, 25 cycles, pause, 100 cycles, start, 5 cycles -> exactly 3 ticks; sec=03, prescaler resumed (3rd tick 5 cycles after resume).
- Same-cycle start+pause+stop in RUN -> DONE; then start -> IDLE with all zeros; start -> RUN.
- Preload to 99:58 via run at CLK_HZ=2, speed=255 -> after the 99:59 tick state=DONE, no further ticks, dist_bcd saturated at 999.
- auto_page=1, NUM_PAGES=3, PAGE_SEC=2: page sequence 0,1,2,0 every 2 ticks; pause freezes page. auto_page=0, page_sel=3 -> page=0.
- Assert reset mid-RUN between ticks -> all outputs 0 immediately (async), state=IDLE. With WORKOUT_LAP_EN: lap at 00:07 -> lap_time_bcd=0007.

Source files
------------

// File: rtl/workout_session.sv
`default_nettype none
// ============================================================================
// workout_session : treadmill run/pause/stop session controller with BCD
// time, BCD distance, 1 Hz tick and display paging. Lap capture: WORKOUT_LAP_EN.
// Revision: 1.0
// ============================================================================
module workout_session #(
  parameter int CLK_HZ      = 50000000,
  parameter int SPEED_W     = 8,
  parameter int DIST_DIGITS = 3,
  parameter int NUM_PAGES   = 3,
  parameter int PAGE_SEC    = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     stop,
  input  logic [SPEED_W-1:0]       speed,
  input  logic                     auto_page,
  input  logic [1:0]               page_sel,
`ifdef WORKOUT_LAP_EN
  input  logic                     lap,
  output logic [15:0]              lap_time_bcd,
  output logic [4*DIST_DIGITS-1:0] lap_dist_bcd,
`endif
  output logic [7:0]               min_bcd,
  output logic [7:0]               sec_bcd,
  output logic [4*DIST_DIGITS-1:0] dist_bcd,
  output logic [1:0]               state,
  output logic [1:0]               page,
  output logic                     tick_1hz
);

  localparam int                  c_pre_w     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int                  c_dist_w    = 4 * DIST_DIGITS;
  localparam logic [c_pre_w-1:0]  c_pre_max   = c_pre_w'(CLK_HZ - 1);
  localparam logic [c_pre_w-1:0]  c_pre_one   = c_pre_w'(1);
  localparam logic [c_dist_w-1:0] c_dist_max  = {DIST_DIGITS{4'h9}};
  localparam logic [2:0]          c_num_pages = 3'(NUM_PAGES);
  localparam logic [1:0]          c_last_page = 2'(NUM_PAGES - 1);
  localparam logic [3:0]          c_psec_last = 4'(PAGE_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [c_pre_w-1:0]  pre_q, pre_d;
  logic [7:0]          min_q, min_d, sec_q, sec_d;
  logic [c_dist_w-1:0] dist_q, dist_d;
  logic [8:0]          res_q, res_d;
  logic [3:0]          psec_q, psec_d;
  logic [1:0]          page_q, page_d;
  logic                tick_q, tick_d;
  logic                w_tick, w_clear;
  logic [9:0]          w_res_sum;
`ifdef WORKOUT_LAP_EN
  logic [15:0]         lap_time_q, lap_time_d;
  logic [c_dist_w-1:0] lap_dist_q, lap_dist_d;
`endif

  function automatic logic [c_dist_w-1:0] bcd_inc(input logic [c_dist_w-1:0] v);
    logic [c_dist_w-1:0] r;
    logic                carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIST_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Stop and pause both pre-empt counting on the cycle they arrive.
  assign w_tick    = (state_q == S_RUN) && !stop && !pause && (pre_q == c_pre_max);
  assign w_clear   = (state_q == S_DONE) && start;
  assign w_res_sum = {1'b0, res_q} + 10'(speed);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    min_d   = min_q;
    sec_d   = sec_q;
    dist_d  = dist_q;
    res_d   = res_q;
    psec_d  = psec_q;
    page_d  = page_q;
    tick_d  = w_tick;

    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (stop)        state_d = S_DONE;
        else if (pause)  state_d = S_PAUSE;
        else if (w_tick) pre_d   = '0;
        else             pre_d   = pre_q + c_pre_one;
      end
      S_PAUSE: begin
        if (stop)                 state_d = S_DONE;
        else if (!pause && start) state_d = S_RUN;
      end
      S_DONE: if (start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (w_tick) begin
      if (sec_q == 8'h59) begin
        sec_d = 8'h00;
        if (min_q[3:0] == 4'd9) min_d = {min_q[7:4] + 4'd1, 4'd0};
        else                    min_d = {min_q[7:4], min_q[3:0] + 4'd1};
      end else if (sec_q[3:0] == 4'd9) begin
        sec_d = {sec_q[7:4] + 4'd1, 4'd0};
      end else begin
        sec_d = {sec_q[7:4], sec_q[3:0] + 4'd1};
      end
      if (min_q == 8'h99 && sec_q == 8'h58) state_d = S_DONE;

      // 360 residue units of 0.1 km/h-seconds make one 10 m step.
      if (w_res_sum >= 10'd360) begin
        res_d = 9'(w_res_sum - 10'd360);
        if (dist_q != c_dist_max) dist_d = bcd_inc(dist_q);
      end else begin
        res_d = w_res_sum[8:0];
      end
    end

    if (w_clear) begin
      pre_d  = '0;
      min_d  = '0;
      sec_d  = '0;
      dist_d = '0;
      res_d  = '0;
      psec_d = '0;
    end

    if (!auto_page) begin
      page_d = ({1'b0, page_sel} < c_num_pages) ? page_sel : 2'd0;
    end else if (w_clear) begin
      page_d = 2'd0;
    end else if (w_tick) begin
      if (psec_q >= c_psec_last) begin
        psec_d = '0;
        page_d = (page_q >= c_last_page) ? 2'd0 : page_q + 2'd1;
      end else begin
        psec_d = psec_q + 4'd1;
      end
    end
  end

`ifdef WORKOUT_LAP_EN
  always_comb begin
    lap_time_d = lap_time_q;
    lap_dist_d = lap_dist_q;
    if (w_clear) begin
      lap_time_d = '0;
      lap_dist_d = '0;
    end else if (lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
      lap_time_d = {min_d, sec_d};
      lap_dist_d = dist_d;
    end
  end
`endif

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      dist_q     <= '0;
      res_q      <= '0;
      psec_q     <= '0;
      page_q     <= '0;
      tick_q     <= 1'b0;
`ifdef WORKOUT_LAP_EN
      lap_time_q <= '0;
      lap_dist_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      dist_q     <= dist_d;
      res_q      <= res_d;
      psec_q     <= psec_d;
      page_q     <= page_d;
      tick_q     <= tick_d;
`ifdef WORKOUT_LAP_EN
      lap_time_q <= lap_time_d;
      lap_dist_q <= lap_dist_d;
`endif
    end
  end

  assign min_bcd  = min_q;
  assign sec_bcd  = sec_q;
  assign dist_bcd = dist_q;
  assign state    = state_q;
  assign page     = page_q;
  assign tick_1hz = tick_q;
`ifdef WORKOUT_LAP_EN
  assign lap_time_bcd = lap_time_q;
  assign lap_dist_bcd = lap_dist_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_workout_session.sv
`default_nettype none
// ============================================================================
// tb_workout_session : self-checking bench for workout_session against an
// integer-seconds reference model. Revision: 1.0
// ============================================================================
module tb_workout_session;

  localparam int CLK_HZ      = 4;
  localparam int DIST_DIGITS = 3;
  localparam int NUM_PAGES   = 3;
  localparam int PAGE_SEC    = 2;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        start    = 1'b0;
  logic        pause    = 1'b0;
  logic        stop     = 1'b0;
  logic        lap      = 1'b0;
  logic [7:0]  speed    = 8'd0;
  logic        auto_page = 1'b0;
  logic [1:0]  page_sel = 2'd0;
  logic [7:0]  min_bcd, sec_bcd;
  logic [11:0] dist_bcd;
  logic [1:0]  state, page;
  logic        tick_1hz;
`ifdef WORKOUT_LAP_EN
  logic [15:0] lap_time_bcd;
  logic [11:0] lap_dist_bcd;
`endif

  workout_session #(
    .CLK_HZ(CLK_HZ), .SPEED_W(8), .DIST_DIGITS(DIST_DIGITS),
    .NUM_PAGES(NUM_PAGES), .PAGE_SEC(PAGE_SEC)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .speed(speed), .auto_page(auto_page), .page_sel(page_sel),
`ifdef WORKOUT_LAP_EN
    .lap(lap), .lap_time_bcd(lap_time_bcd), .lap_dist_bcd(lap_dist_bcd),
`endif
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .dist_bcd(dist_bcd),
    .state(state), .page(page), .tick_1hz(tick_1hz)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;
  int dut_ticks = 0;

  always @(negedge CLOCK_50) if (tick_1hz === 1'b1) dut_ticks++;

  logic [31:0] dut_vec;
  assign dut_vec = {min_bcd, sec_bcd, dist_bcd, state, page};

  // Reference model: elapsed whole seconds, distance in 10 m units.
  int          m_state, m_phase, m_secs, m_res, m_dist, m_page, m_psec, m_ticks;
  logic [15:0] m_lap_time;
  logic [11:0] m_lap_dist;

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] model_vec();
    return {bcd2(m_secs / 60), bcd2(m_secs % 60), bcd3(m_dist), 2'(m_state), 2'(m_page)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_secs = 0; m_res = 0; m_dist = 0;
    m_page = 0; m_psec = 0; m_lap_time = '0; m_lap_dist = '0;
  endtask

  task automatic model_edge(input bit st, input bit pa, input bit sp, input bit lp);
    bit tk, clr;
    int prev;
    tk = 0; clr = 0; prev = m_state;
    case (m_state)
      0: if (st) m_state = 1;
      1: begin
        if (sp) m_state = 3;
        else if (pa) m_state = 2;
        else if (m_phase == CLK_HZ - 1) begin m_phase = 0; tk = 1; end
        else m_phase++;
      end
      2: begin
        if (sp) m_state = 3;
        else if (!pa && st) m_state = 1;
      end
      default: if (st) begin m_state = 0; clr = 1; end
    endcase
    if (tk) begin
      m_ticks++;
      m_secs++;
      m_res += int'(speed);
      if (m_res >= 360) begin
        m_res -= 360;
        if (m_dist < 999) m_dist++;
      end
      if (m_secs == 99 * 60 + 59) m_state = 3;
    end
    if (clr) begin
      m_phase = 0; m_secs = 0; m_res = 0; m_dist = 0; m_psec = 0;
      m_lap_time = '0; m_lap_dist = '0;
    end
    if (!auto_page) m_page = (int'(page_sel) < NUM_PAGES) ? int'(page_sel) : 0;
    else if (clr) m_page = 0;
    else if (tk) begin
      m_psec++;
      if (m_psec == PAGE_SEC) begin
        m_psec = 0;
        m_page = (m_page + 1) % NUM_PAGES;
      end
    end
    if (lp && !clr && (prev == 1 || prev == 2)) begin
      m_lap_time = {bcd2(m_secs / 60), bcd2(m_secs % 60)};
      m_lap_dist = bcd3(m_dist);
    end
  endtask

  task automatic cycle(input bit st, input bit pa, input bit sp, input bit lp);
    start = st; pause = pa; stop = sp; lap = lp;
    @(posedge CLOCK_50);
    model_edge(st, pa, sp, lp);
    @(negedge CLOCK_50);
    #1;
    start = 0; pause = 0; stop = 0; lap = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 0; pause = 0; stop = 0; lap = 0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    auto_page = 0; page_sel = 0;
    do_reset();
    n_cmp++; if (dut_vec !== 32'h0) begin n_bad++; $display("FAIL reset_vec: got %h want %h", dut_vec, 32'h0); end
    n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick_1hz); end
`ifdef WORKOUT_LAP_EN
    n_cmp++; if ({lap_time_bcd, lap_dist_bcd} !== 28'h0) begin n_bad++; $display("FAIL reset_lap: got %h want 0", {lap_time_bcd, lap_dist_bcd}); end
`endif
    cycle(0, 1, 1, 0);
    n_cmp++; if (dut_vec !== model_vec()) begin n_bad++; $display("FAIL idle_ignore: got %h want %h", dut_vec, model_vec()); end
  endtask

  task automatic test_basic_run();
    int t0;
    do_reset();
    speed = 8'd120; t0 = dut_ticks;
    cycle(1, 0, 0, 0);
    run(65 * CLK_HZ);
    n_cmp++; if (dut_vec !== model_vec()) begin n_bad++; $display("FAIL basic_vec: got %h want %h", dut_vec, model_vec()); end
    n_cmp++; if ({min_bcd, sec_bcd} !== 16'h0105) begin n_bad++; $display("FAIL basic_time: got %h want 0105", {min_bcd, sec_bcd}); end
    n_cmp++; if (dist_bcd !== 12'h021) begin n_bad++; $display("FAIL basic_dist: got %h want 021", dist_bcd); end
    n_cmp++; if (dut_ticks - t0 !== 65) begin n_bad++; $display("FAIL basic_ticks: got %0d want 65", dut_ticks - t0); end
  endtask

  task automatic test_pause_resume();
    int t0;
    do_reset();
    speed = 8'd37; t0 = dut_ticks;
    cycle(1, 0, 0, 0);
    run(2 * CLK_HZ + 1);
    cycle(0, 1, 0, 0);
    run(30);
    n_cmp++; if ({state, sec_bcd} !== {2'd2, 8'h02}) begin n_bad++; $display("FAIL pause_frozen: got %h want 202", {state, sec_bcd}); end
    cycle(1, 0, 0, 0);
    run(CLK_HZ - 2);
    n_cmp++; if (sec_bcd !== 8'h02) begin n_bad++; $display("FAIL resume_early: got %h want 02", sec_bcd); end
    run(1);
    n_cmp++; if (sec_bcd !== 8'h03) begin n_bad++; $display("FAIL resume_tick: got %h want 03", sec_bcd); end
    n_cmp++; if (dut_ticks - t0 !== 3) begin n_bad++; $display("FAIL resume_count: got %0d want 3", dut_ticks - t0); end
    n_cmp++; if (dut_vec !== model_vec()) begin n_bad++; $display("FAIL resume_vec: got %h want %h", dut_vec, model_vec()); end
  endtask

  task automatic test_cmd_priority();
    cycle(1, 1, 1, 0);
    n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL prio_all_done: got %0d want 3", state); end
    n_cmp++; if (dut_vec !== model_vec()) begin n_bad++; $display("FAIL prio_hold: got %h want %h", dut_vec, model_vec()); end
    cycle(1, 0, 0, 0);
    n_cmp++; if (dut_vec !== 32'h0) begin n_bad++; $display("FAIL done_clear: got %h want 0", dut_vec); end
    cycle(1, 0, 0, 0);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL restart: got %0d want 1", state); end
    cycle(1, 1, 0, 0);
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL prio_pause: got %0d want 2", state); end
    cycle(1, 0, 1, 0);
    n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL prio_stop: got %0d want 3", state); end
  endtask

  task automatic test_pages();
    logic [1:0] exp_pg [4];
    exp_pg = '{2'd0, 2'd1, 2'd2, 2'd0};
    auto_page = 1; page_sel = 2;
    do_reset();
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (page !== exp_pg[k]) begin n_bad++; $display("FAIL page_seq%0d: got %0d want %0d", k, page, exp_pg[k]); end
      run(PAGE_SEC * CLK_HZ);
    end
    cycle(0, 1, 0, 0);
    run(5 * CLK_HZ);
    n_cmp++; if (page !== 2'd1) begin n_bad++; $display("FAIL page_freeze: got %0d want 1", page); end
    cycle(1, 0, 0, 0);
    run(2 * CLK_HZ);
    n_cmp++; if (page !== 2'd2) begin n_bad++; $display("FAIL page_resume: got %0d want 2", page); end
    auto_page = 0; page_sel = 3;
    cycle(0, 0, 0, 0);
    n_cmp++; if (page !== 2'd0) begin n_bad++; $display("FAIL page_sel_oor: got %0d want 0", page); end
    page_sel = 2;
    cycle(0, 0, 0, 0);
    n_cmp++; if (page !== 2'd2) begin n_bad++; $display("FAIL page_sel2: got %0d want 2", page); end
    n_cmp++; if (dut_vec !== model_vec()) begin n_bad++; $display("FAIL page_vec: got %h want %h", dut_vec, model_vec()); end
  endtask

`ifdef WORKOUT_LAP_EN
  task automatic test_lap();
    auto_page = 0; page_sel = 0; speed = 8'd200;
    do_reset();
    cycle(1, 0, 0, 0);
    run(7 * CLK_HZ);
    cycle(0, 0, 0, 1);
    n_cmp++; if (lap_time_bcd !== 16'h0007) begin n_bad++; $display("FAIL lap_time: got %h want 0007", lap_time_bcd); end
    n_cmp++; if (lap_dist_bcd !== m_lap_dist) begin n_bad++; $display("FAIL lap_dist: got %h want %h", lap_dist_bcd, m_lap_dist); end
    run(3 * CLK_HZ);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    n_cmp++; if (lap_time_bcd !== 16'h0007) begin n_bad++; $display("FAIL lap_done_ignored: got %h want 0007", lap_time_bcd); end
    cycle(1, 0, 0, 0);
    n_cmp++; if ({lap_time_bcd, lap_dist_bcd} !== 28'h0) begin n_bad++; $display("FAIL lap_clear: got %h want 0", {lap_time_bcd, lap_dist_bcd}); end
  endtask
`endif

  task automatic test_random();
    int r;
    bit st, pa, sp, lp;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      speed = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) auto_page = ~auto_page;
      if ($urandom_range(0, 49) == 0) page_sel = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 199);
      st = (r < 6) || (r == 11);
      pa = (r >= 6 && r < 10) || (r == 11);
      sp = (r == 10) || (r == 11);
      lp = ($urandom_range(0, 19) == 0);
      cycle(st, pa, sp, lp);
      n_cmp++; if (dut_vec !== model_vec()) begin n_bad++; $display("FAIL rand_vec@%0d: got %h want %h", i, dut_vec, model_vec()); end
`ifdef WORKOUT_LAP_EN
      n_cmp++; if ({lap_time_bcd, lap_dist_bcd} !== {m_lap_time, m_lap_dist}) begin
        n_bad++; $display("FAIL rand_lap@%0d: got %h want %h", i, {lap_time_bcd, lap_dist_bcd}, {m_lap_time, m_lap_dist});
      end
`endif
    end
    n_cmp++; if (dut_ticks !== m_ticks) begin n_bad++; $display("FAIL rand_ticks: got %0d want %0d", dut_ticks, m_ticks); end
  endtask

  task automatic test_async_reset();
    auto_page = 1;
    do_reset();
    speed = 8'd250;
    cycle(1, 0, 0, 0);
    run(3 * CLK_HZ + 2);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (dut_vec !== 32'h0) begin n_bad++; $display("FAIL async_reset: got %h want 0", dut_vec); end
    n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL async_tick: got %b want 0", tick_1hz); end
    @(negedge CLOCK_50);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    int t0;
    auto_page = 0; page_sel = 1;
    do_reset();
    speed = 8'd255; t0 = dut_ticks;
    cycle(1, 0, 0, 0);
    run(5998 * CLK_HZ);
    n_cmp++; if ({state, min_bcd, sec_bcd} !== {2'd1, 16'h9958}) begin n_bad++; $display("FAIL sat_9958: got %h want 19958", {state, min_bcd, sec_bcd}); end
    n_cmp++; if (dist_bcd !== 12'h999) begin n_bad++; $display("FAIL sat_dist: got %h want 999", dist_bcd); end
    run(CLK_HZ);
    n_cmp++; if ({state, min_bcd, sec_bcd} !== {2'd3, 16'h9959}) begin n_bad++; $display("FAIL sat_done: got %h want 39959", {state, min_bcd, sec_bcd}); end
    run(5 * CLK_HZ);
    n_cmp++; if (dut_ticks - t0 !== 5999) begin n_bad++; $display("FAIL sat_ticks: got %0d want 5999", dut_ticks - t0); end
    n_cmp++; if (dut_vec !== model_vec()) begin n_bad++; $display("FAIL sat_vec: got %h want %h", dut_vec, model_vec()); end
  endtask

  initial begin
    model_reset();
    m_ticks = 0;
    test_reset();
    test_basic_run();
    test_pause_resume();
    test_cmd_priority();
    test_pages();
`ifdef WORKOUT_LAP_EN
    test_lap();
`endif
    test_random();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
